// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU byte FIFO feeding an 8N1 LSB-first serialiser on txd.
// Ports: clk, reset (async high), uart_out/uart_wrreq in; uart_full, fifo_count, tx_busy, overflow, txd out.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            uart_out,
  input  logic                  uart_wrreq,
  output logic                  uart_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  tx_busy,
  output logic                  overflow,
  output logic                  txd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0] BAUD_LAST =
    16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  full_q;
  logic                  ovf_q;

  logic [1:0]  state;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        txd_q;
  logic        busy_q;

  logic baud_done;
  logic has_data;
  logic wr_ok;
  logic pop;

  assign baud_done = (baud == BAUD_LAST);
  assign has_data  = (count != '0);

  // Full is the registered pre-edge value, so a pop on
  // the same edge never makes room for a write.
  assign wr_ok = uart_wrreq && !full_q;

  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      state == S_IDLE: pop = has_data;
      state == S_STOP: pop = has_data && baud_done;
      default:         pop = 1'b0;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (wr_ok && !pop)
      count_nxt = count + 1'b1;
    else if (!wr_ok && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= uart_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_FULL);
      if (uart_wrreq && full_q)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            shift  <= mem[rd_ptr];
            baud   <= '0;
            txd_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            txd_q   <= shift[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              // Next bit is presented as the shift happens.
              txd_q   <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              // Chain straight into the next frame.
              shift <= mem[rd_ptr];
              txd_q <= 1'b0;
              state <= S_START;
            end else begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_full  = full_q;
  assign fifo_count = count;
  assign tx_busy    = busy_q;
  assign overflow   = ovf_q;
  assign txd        = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Bytes are queued on write and checked by a serial decoder.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DL2 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] uart_out = '0;
  logic       uart_wrreq = 1'b0;
  logic       uart_full;
  logic [DL2:0] fifo_count;
  logic       tx_busy;
  logic       overflow;
  logic       txd;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2(DL2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_out(uart_out),
    .uart_wrreq(uart_wrreq),
    .uart_full(uart_full),
    .fifo_count(fifo_count),
    .tx_busy(tx_busy),
    .overflow(overflow),
    .txd(txd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  int rx_n = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int max_cnt = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_busy === 1'b1) busy_cnt++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  // Serial decoder: ph counts negedges from first low sample.
  int ph = 0;
  logic dec_on = 1'b0;
  logic [7:0] sh = '0;
  always @(negedge clk) begin
    if (reset) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (txd === 1'b0) begin
        dec_on = 1'b1;
        ph = 0;
      end
    end else begin
      ph++;
      if (ph == 2) chk("start bit", txd, 0);
      if (ph >= 5 && ph <= 33 && (ph % 4) == 1)
        sh = {txd, sh[7:1]};
      if (ph == 37) begin
        chk("stop bit", txd, 1);
        if (q.size() == 0) chk("extra frame", 1, 0);
        else chk("rx byte", sh, q.pop_front());
        rx_n++;
        dec_on = 1'b0;
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    uart_out = b;
    uart_wrreq = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    uart_wrreq = 1'b0;
    reset = 1'b1;
    q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((q.size() != 0 || tx_busy !== 1'b0 ||
            fifo_count != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    logic [39:0] wave;
    logic [39:0] exp_w;
    logic [7:0] b;
    int c0;
    int r0;
    int sent;
    int guard;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst txd", txd, 1);
    chk("rst busy", tx_busy, 0);
    chk("rst full", uart_full, 0);
    chk("rst cnt", fifo_count, 0);
    chk("rst ovf", overflow, 0);

    // Single byte 0xA5
    b = 8'hA5;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < CPB; j++)
        exp_w[k*CPB+j] = (k == 0) ? 1'b0 :
                         (k == 9) ? 1'b1 : b[k-1];
    busy_cnt = 0;
    wr(b);
    q.push_back(b);
    @(negedge clk);
    uart_wrreq = 1'b0;
    chk("1b cnt1", fifo_count, 1);
    chk("1b txd idle", txd, 1);
    @(negedge clk);
    chk("1b cnt0", fifo_count, 0);
    for (int i = 0; i < 40; i++) begin
      wave[i] = txd;
      @(negedge clk);
    end
    chk("1b wave", wave, exp_w);
    chk("1b busy end", tx_busy, 0);
    chk("1b busy cyc", busy_cnt, 40);
    drain("1b drain", 100);

    // Back-to-back frames
    r0 = rx_n;
    busy_cnt = 0;
    wr(8'h00);
    c0 = cyc;
    q.push_back(8'h00);
    wr(8'hFF);
    q.push_back(8'hFF);
    wr(8'h55);
    q.push_back(8'h55);
    @(negedge clk);
    uart_wrreq = 1'b0;
    drain("b2b drain", 300);
    chk("b2b span", cyc - c0, 122);
    chk("b2b busy cyc", busy_cnt, 120);
    chk("b2b frames", rx_n - r0, 3);
    chk("b2b ovf", overflow, 0);

    // Fill, overflow, then reset during DATA bit 3
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr(8'(8'h10 + i));
      if (i < 5) q.push_back(8'(8'h10 + i));
    end
    @(negedge clk);
    uart_wrreq = 1'b0;
    chk("ovf full", uart_full, 1);
    chk("ovf cnt", fifo_count, 4);
    chk("ovf flag", overflow, 1);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    q.delete();
    #1;
    chk("mid rst txd", txd, 1);
    chk("mid rst busy", tx_busy, 0);
    chk("mid rst cnt", fifo_count, 0);
    chk("mid rst ovf", overflow, 0);
    chk("mid rst full", uart_full, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    r0 = rx_n;
    wr(8'h3C);
    q.push_back(8'h3C);
    @(negedge clk);
    uart_wrreq = 1'b0;
    drain("post rst drain", 100);
    chk("post rst frames", rx_n - r0, 1);

    // Write while full on the STOP terminal-count pop edge
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(8'(8'h20 + i));
      q.push_back(8'(8'h20 + i));
    end
    @(negedge clk);
    uart_wrreq = 1'b0;
    chk("wf full", uart_full, 1);
    chk("wf cnt4", fifo_count, 4);
    chk("wf ovf0", overflow, 0);
    repeat (36) @(negedge clk);
    chk("wf pre cnt", fifo_count, 4);
    uart_out = 8'h99;
    uart_wrreq = 1'b1;
    @(negedge clk);
    uart_wrreq = 1'b0;
    chk("wf ovf1", overflow, 1);
    chk("wf cnt3", fifo_count, 3);
    chk("wf not full", uart_full, 0);
    chk("wf new start", txd, 0);
    drain("wf drain", 400);

    // Pointer wrap with writes paced by uart_full
    do_reset();
    r0 = rx_n;
    max_cnt = 0;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (!uart_full) begin
        uart_out = 8'(sent);
        uart_wrreq = 1'b1;
        q.push_back(8'(sent));
        sent++;
      end else begin
        uart_wrreq = 1'b0;
      end
    end
    @(negedge clk);
    uart_wrreq = 1'b0;
    chk("wrap sent", sent, 40);
    drain("wrap drain", 2500);
    chk("wrap frames", rx_n - r0, 40);
    chk("wrap max cnt", max_cnt, 4);
    chk("wrap ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit end of the nibu CPU UART byte interface: consumes the CPU's uart_out/uart_wrreq write strobe and returns uart_full as backpressure.
- Buffers bytes in a small synchronous FIFO and serialises them 8N1, LSB first, on txd.
- Sits between the nibu core and the board TX pin; the RX-side block supplies uart_in/uart_empty/uart_rdreq.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes; legal range 1..8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- uart_out  input  8  byte from CPU; sampled only when uart_wrreq=1.
- uart_wrreq  input  1  single-cycle write strobe from CPU; one byte per high cycle.
- uart_full  output  1  FIFO holds 2**DEPTH_LOG2 bytes; registered.
- fifo_count  output  DEPTH_LOG2+1  bytes currently buffered (excludes the byte in the shifter).
- tx_busy  output  1  1 while any frame is on the line (START/DATA/STOP).
- overflow  output  1  sticky; set when a write is attempted while uart_full=1.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, removal synchronous to clk): txd=1, tx_busy=0, uart_full=0, fifo_count=0, overflow=0, state=IDLE, FIFO pointers=0. FIFO RAM contents are don't-care. Reset mid-frame truncates the frame immediately; txd returns high in the same reset assertion.
- FIFO write: on an edge with uart_wrreq=1 and uart_full=0, store uart_out at the write pointer and increment the pointer (wraps modulo depth).
- Write while full: on an edge with uart_wrreq=1 and uart_full=1, drop the byte, set overflow, leave FIFO unchanged. The full test uses the registered pre-edge value, so a pop on the same edge does not admit the write.
- Write and pop on the same edge: count is unchanged. A write into an empty FIFO is not poppable until the next edge.
- fifo_count and uart_full update on the same edge as the write/pop.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1; a bit counter counts 0..7.
- IDLE: txd=1, tx_busy=0. If fifo_count!=0 on an edge: pop the head byte into the shift register, clear the baud counter, go to START.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7 completes, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. On the terminal count:
  - if fifo_count!=0, pop and go directly to START;
  - otherwise go to IDLE.
- Back-to-back frames are therefore exactly 10*CLKS_PER_BIT cycles apart.
- Latency: a write on edge n into an empty FIFO with FSM in IDLE gives pop on edge n+1; txd falls after edge n+1.
- txd, tx_busy and uart_full are driven from registers (glitch-free).
- fifo_count never exceeds 2**DEPTH_LOG2. Pointer wrap-around must be exercised without data corruption.

Test Plan:
- Single byte (CLKS_PER_BIT=4): write 0xA5 at edge n -> txd low from n+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1, each 4 cycles, then high 4 cycles; tx_busy high for exactly 40 cycles; fifo_count 0 → 1 → 0.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive edges -> three frames with no idle gap (120 cycles total), decoded bytes match in order, overflow=0.
- Fill/overflow (DEPTH_LOG2=2): 6 consecutive writes 0x10..0x15 while the first is transmitting -> 0x10 enters the shifter; 0x11..0x14 buffered, uart_full=1; 0x15 dropped with overflow=1; line carries 0x10..0x14 only.
- Write on full with simultaneous pop: hold FIFO full and assert uart_wrreq on the STOP terminal-count edge -> write rejected, overflow set, fifo_count drops to depth-1.
- Pointer wrap: stream 40 incrementing bytes with writes paced by uart_full -> serial decoder receives 0..39 exactly; fifo_count never exceeds 4.
- Reset mid-frame: assert reset during DATA bit 3 -> txd=1, tx_busy=0, fifo_count=0, overflow=0 immediately. After release, write 0x3C -> a clean full frame of 0x3C.
